fifo_rr_sched: RTL

FIFO_RR_SCHED -- requirements
Module: fifo_rr_sched

---
 rtl/fifo_sched_pkg.sv | 31 +++
 rtl/fifo_rr_sched_rr_pick.sv | 27 ++
 rtl/fifo_rr_sched.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/fifo_sched_pkg.sv
// fifo_sched_pkg: scheduler state type and the rotating first-one
// search shared by the fifo_rr_sched round-robin drain block.
package fifo_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    FLUSH
  } sched_state_t;

  localparam int MaxPorts = 8;

  // {found, index}: first set bit of req[n-1:0] scanning up from start
  function automatic logic [3:0] rrFirst(
    input logic [MaxPorts-1:0] req,
    input int                  start,
    input int                  n
  );
    logic [3:0] res;
    int         j;
    res = '0;
    for (int k = MaxPorts - 1; k >= 0; k--) begin
      if (k < n) begin
        j = (start + k) % n;
        if (req[3'(j)]) res = {1'b1, 3'(j)};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/fifo_rr_sched_rr_pick.sv
// rr_pick: combinational rotating priority picker over an N-bit
// request vector, starting the scan at a given index.
module rr_pick
  import fifo_sched_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [MaxPorts-1:0] reqExt;
  logic [3:0]          res;

  always_comb begin
    reqExt        = '0;
    reqExt[N-1:0] = req;
    res           = rrFirst(reqExt, int'(start), N);
  end

  assign found = res[3];
  assign idx   = IW'(res[2:0]);

endmodule

// File: rtl/fifo_rr_sched.sv
// fifo_rr_sched: round-robin burst drain of NPORTS show-ahead FIFOs
// into one registered output. FIFO_RR_SCHED_STATS_EN adds counters.
module fifo_rr_sched
  import fifo_sched_pkg::sched_state_t;
#(
  parameter int NPORTS = 4,
  parameter int WIDTH  = 16,
  parameter int BURST  = 4,
  localparam int PW    = $clog2(NPORTS)
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic [NPORTS*WIDTH-1:0] fifo_q,
  input  logic [NPORTS-1:0]       fifo_empty,
  output logic [NPORTS-1:0]       fifo_rdreq,
  input  logic [NPORTS-1:0]       port_en,
  input  logic                    flush,
  output logic                    flush_done,
  output logic [WIDTH-1:0]        out_data,
  output logic [PW-1:0]           out_port,
  output logic                    out_valid,
  input  logic                    out_ready
`ifdef FIFO_RR_SCHED_STATS_EN
  ,
  input  logic [PW-1:0]           stat_sel,
  output logic [15:0]             stat_cnt
`endif
);

  sched_state_t      state, stateNxt;
  logic [PW-1:0]     last, lastNxt;
  logic [PW-1:0]     rrStart, rrIdx, flIdx, grantIdx;
  logic [3:0]        bcnt, bcntNxt;
  logic [NPORTS-1:0] elig;
  logic              acc, rrFound, flFound;
  logic              grant, flushRd;

  assign acc     = ~out_valid | out_ready;
  assign elig    = ~fifo_empty & port_en;
  assign rrStart = (last == PW'(NPORTS - 1)) ? '0 : last + 1'b1;

  rr_pick #(.N(NPORTS)) uRr (
    .req   (elig),
    .start (rrStart),
    .found (rrFound),
    .idx   (rrIdx)
  );

  // flush drains lowest index first, regardless of port_en
  rr_pick #(.N(NPORTS)) uFl (
    .req   (~fifo_empty),
    .start ('0),
    .found (flFound),
    .idx   (flIdx)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= fifo_sched_pkg::IDLE;
      last  <= PW'(NPORTS - 1);
      bcnt  <= '0;
    end else begin
      state <= stateNxt;
      last  <= lastNxt;
      bcnt  <= bcntNxt;
    end
  end

  always_comb begin
    stateNxt = state;
    lastNxt  = last;
    bcntNxt  = bcnt;
    grant    = 1'b0;
    grantIdx = rrIdx;
    flushRd  = 1'b0;
    unique case (state)
      fifo_sched_pkg::IDLE: begin
        if (flush) begin
          stateNxt = fifo_sched_pkg::FLUSH;
        end else if (acc && rrFound) begin
          grant    = 1'b1;
          lastNxt  = rrIdx;
          bcntNxt  = 4'd1;
          stateNxt = fifo_sched_pkg::BURST;
        end
      end
      fifo_sched_pkg::BURST: begin
        if (flush) begin
          stateNxt = fifo_sched_pkg::FLUSH;
        end else if (acc) begin
          if (elig[last] && bcnt < 4'(BURST)) begin
            grant    = 1'b1;
            grantIdx = last;
            bcntNxt  = bcnt + 4'd1;
          end else if (rrFound) begin
            grant    = 1'b1;
            lastNxt  = rrIdx;
            bcntNxt  = 4'd1;
          end else begin
            stateNxt = fifo_sched_pkg::IDLE;
          end
        end
      end
      fifo_sched_pkg::FLUSH: begin
        if (flFound) begin
          flushRd = 1'b1;
        end else begin
          stateNxt = fifo_sched_pkg::IDLE;
          lastNxt  = PW'(NPORTS - 1);
        end
      end
      default: stateNxt = fifo_sched_pkg::IDLE;
    endcase
  end

  always_comb begin
    fifo_rdreq = '0;
    if (resetn) begin
      if (grant)        fifo_rdreq[grantIdx] = 1'b1;
      else if (flushRd) fifo_rdreq[flIdx]    = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_port   <= '0;
      flush_done <= 1'b0;
    end else begin
      flush_done <= (state == fifo_sched_pkg::FLUSH) && !flFound;
      if (grant) begin
        out_valid <= 1'b1;
        out_data  <= fifo_q[grantIdx*WIDTH +: WIDTH];
        out_port  <= grantIdx;
      end else if (flush || state == fifo_sched_pkg::FLUSH || out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef FIFO_RR_SCHED_STATS_EN
  logic [15:0] statCnt [NPORTS];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NPORTS; i++) statCnt[i] <= '0;
      stat_cnt <= '0;
    end else begin
      for (int i = 0; i < NPORTS; i++) begin
        if (flush)
          statCnt[i] <= '0;
        else if (out_valid && out_ready && out_port == PW'(i)
                 && statCnt[i] != 16'hFFFF)
          statCnt[i] <= statCnt[i] + 16'd1;
      end
      stat_cnt <= statCnt[stat_sel];
    end
  end
`endif

endmodule
